// File: rtl/adc_encode_clk_mc.sv
// Multi-channel ADC encode clock generator: divides AXI_CLK into phase-locked encode clocks,
// reloads divider/offsets at period boundaries. Per-channel offsets enabled by ADC_ENC_PHASE_OFFSET_EN.
module adc_encode_clk_mc #(
  parameter int NUM_CHANNELS = 4,
  parameter int DIV_WIDTH    = 16,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                              AXI_CLK,
  input  logic                              RESET,
  input  logic                              ENABLE,
  input  logic [DIV_WIDTH-1:0]              CLOCK_DIV,
  input  logic [NUM_CHANNELS*DIV_WIDTH-1:0] PHASE_OFFSET,
  input  logic                              DIV_LOAD,
  output logic [NUM_CHANNELS-1:0]           ENCODE_CLK,
  output logic [NUM_CHANNELS-1:0]           SAMPLE_STROBE,
  output logic [CNT_WIDTH-1:0]              SAMPLE_COUNT,
  output logic                              RUNNING,
  output logic [DIV_WIDTH-1:0]              DIV_ACTIVE
);

  localparam int PW = DIV_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [PW-1:0]           cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0]    div_q, div_d;
  logic [DIV_WIDTH-1:0]    sdiv_q, sdiv_d;
  logic                    pend_q, pend_d;
  logic                    running_q, running_d;
  logic [NUM_CHANNELS-1:0] enc_q, enc_d;
  logic [NUM_CHANNELS-1:0] strb_q, strb_d;
  logic [CNT_WIDTH-1:0]    count_q, count_d;
  logic [NUM_CHANNELS-1:0] lvl_s;
  logic [PW-1:0]           period_s;
  logic                    wrap_s;
  logic                    apply_s;
  logic [DIV_WIDTH-1:0]    new_div_s;

  function automatic logic [DIV_WIDTH-1:0] fix_div(input logic [DIV_WIDTH-1:0] d);
    if (d == {DIV_WIDTH{1'b0}}) begin
      return DIV_WIDTH'(1);
    end else begin
      return d;
    end
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    pend_d    = pend_q;
    period_s  = {div_q, 1'b0};
    wrap_s    = (cnt_q == period_s - PW'(1));
    apply_s   = pend_q | DIV_LOAD;
    // a load on the wrap cycle itself bypasses the shadow
    if (DIV_LOAD) begin
      new_div_s = CLOCK_DIV;
      sdiv_d    = CLOCK_DIV;
    end else begin
      new_div_s = sdiv_q;
      sdiv_d    = sdiv_q;
    end
    case (state_q)
      ST_IDLE: begin
        cnt_d  = {PW{1'b0}};
        pend_d = 1'b0;
        div_d  = fix_div(CLOCK_DIV);
        if (ENABLE) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN, ST_DRAIN: begin
        if (ENABLE) begin
          state_d = ST_RUN;
        end else if ((state_q == ST_DRAIN) && wrap_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
        if (wrap_s) begin
          cnt_d  = {PW{1'b0}};
          pend_d = 1'b0;
          if (apply_s) begin
            div_d = fix_div(new_div_s);
          end else begin
            div_d = div_q;
          end
        end else begin
          cnt_d  = cnt_q + PW'(1);
          pend_d = apply_s;
          div_d  = div_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {PW{1'b0}};
        pend_d  = 1'b0;
        div_d   = div_q;
      end
    endcase
    running_d = (state_d != ST_IDLE);
    // the final wrap of a drain already drives the clocks low
    if (running_d && (state_q != ST_IDLE)) begin
      enc_d = lvl_s;
    end else begin
      enc_d = {NUM_CHANNELS{1'b0}};
    end
    strb_d  = enc_d & ~enc_q;
    count_d = count_q + CNT_WIDTH'(strb_d[0]);
  end

`ifdef ADC_ENC_PHASE_OFFSET_EN
  logic [DIV_WIDTH-1:0] off_q  [NUM_CHANNELS];
  logic [DIV_WIDTH-1:0] off_d  [NUM_CHANNELS];
  logic [DIV_WIDTH-1:0] soff_q [NUM_CHANNELS];
  logic [DIV_WIDTH-1:0] soff_d [NUM_CHANNELS];
  logic [PW:0]          ph_s   [NUM_CHANNELS];

  function automatic logic [DIV_WIDTH-1:0] clamp_off(input logic [DIV_WIDTH-1:0] off,
                                                     input logic [DIV_WIDTH-1:0] d);
    logic [PW-1:0] p;
    p = {d, 1'b0};
    if ({1'b0, off} >= p) begin
      return DIV_WIDTH'(p - PW'(1));
    end else begin
      return off;
    end
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (DIV_LOAD) begin
        soff_d[i] = PHASE_OFFSET[i*DIV_WIDTH +: DIV_WIDTH];
      end else begin
        soff_d[i] = soff_q[i];
      end
      // offsets are clamped against the divider they will run with
      if (state_q == ST_IDLE) begin
        off_d[i] = clamp_off(PHASE_OFFSET[i*DIV_WIDTH +: DIV_WIDTH], div_d);
      end else if (wrap_s && apply_s) begin
        off_d[i] = clamp_off(soff_d[i], div_d);
      end else begin
        off_d[i] = off_q[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (cnt_q >= {1'b0, off_q[i]}) begin
        ph_s[i] = {1'b0, cnt_q} - {2'b00, off_q[i]};
      end else begin
        ph_s[i] = {1'b0, cnt_q} + {1'b0, period_s} - {2'b00, off_q[i]};
      end
      lvl_s[i] = (ph_s[i] >= {2'b00, div_q});
    end
  end

  always_ff @(posedge AXI_CLK) begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (RESET) begin
        off_q[i]  <= {DIV_WIDTH{1'b0}};
        soff_q[i] <= {DIV_WIDTH{1'b0}};
      end else begin
        off_q[i]  <= off_d[i];
        soff_q[i] <= soff_d[i];
      end
    end
  end
`else
  logic unused_phase_offset_s;
  assign unused_phase_offset_s = ^PHASE_OFFSET;

  always_comb begin
    lvl_s = {NUM_CHANNELS{(cnt_q >= {1'b0, div_q})}};
  end
`endif

  always_ff @(posedge AXI_CLK) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      cnt_q     <= {PW{1'b0}};
      div_q     <= DIV_WIDTH'(1);
      sdiv_q    <= DIV_WIDTH'(1);
      pend_q    <= 1'b0;
      running_q <= 1'b0;
      enc_q     <= {NUM_CHANNELS{1'b0}};
      strb_q    <= {NUM_CHANNELS{1'b0}};
      count_q   <= {CNT_WIDTH{1'b0}};
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      sdiv_q    <= sdiv_d;
      pend_q    <= pend_d;
      running_q <= running_d;
      enc_q     <= enc_d;
      strb_q    <= strb_d;
      count_q   <= count_d;
    end
  end

  assign ENCODE_CLK    = enc_q;
  assign SAMPLE_STROBE = strb_q;
  assign SAMPLE_COUNT  = count_q;
  assign RUNNING       = running_q;
  assign DIV_ACTIVE    = div_q;

endmodule

// File: tb/tb_adc_encode_clk_mc.sv
// Bench for adc_encode_clk_mc: period-level reference model checked every cycle,
// plus directed scenarios with hand-computed cycle expectations (k = cycles after ENABLE sampled).
module tb_adc_encode_clk_mc;
  localparam int NC = 4;
  localparam int DW = 16;
  localparam int CW = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic           load;
  logic [DW-1:0]  cdiv;
  logic [NC*DW-1:0] poff;
  logic [NC-1:0]  enc;
  logic [NC-1:0]  strb;
  logic [CW-1:0]  cnt;
  logic           running;
  logic [DW-1:0]  div_act;

  int checks = 0;
  int failures = 0;
  int k = 0;

  adc_encode_clk_mc #(.NUM_CHANNELS(NC), .DIV_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .AXI_CLK(clk), .RESET(rst), .ENABLE(en), .CLOCK_DIV(cdiv), .PHASE_OFFSET(poff),
    .DIV_LOAD(load), .ENCODE_CLK(enc), .SAMPLE_STROBE(strb), .SAMPLE_COUNT(cnt),
    .RUNNING(running), .DIV_ACTIVE(div_act)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s k=%0d actual=%0d required=%0d", name, k, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit m_active, m_drain, m_pend, cmp_on;
  int m_pos, m_D, m_sD;
  int m_off[NC];
  int m_soff[NC];
  logic [NC-1:0] e_enc, e_strb;
  int e_cnt, e_div;
  bit e_run;

  function automatic int fixd(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  function automatic int clampo(input int o, input int d);
`ifdef ADC_ENC_PHASE_OFFSET_EN
    return (o >= 2 * d) ? 2 * d - 1 : o;
`else
    return 0;
`endif
  endfunction

  task automatic model_step();
    logic [NC-1:0] nenc;
    int P;
    bit wrap, stop;
    if (rst) begin
      m_active = 0; m_drain = 0; m_pend = 0; m_pos = 0; m_D = 1; m_sD = 1;
      for (int i = 0; i < NC; i++) begin m_off[i] = 0; m_soff[i] = 0; end
      e_enc = '0; e_strb = '0; e_cnt = 0; e_run = 0; e_div = 1;
      cmp_on = 1;
      return;
    end
    nenc = '0;
    if (load) begin
      m_sD = int'(cdiv);
      for (int i = 0; i < NC; i++) m_soff[i] = int'(poff[i*DW +: DW]);
    end
    if (!m_active) begin
      m_D = fixd(int'(cdiv));
      for (int i = 0; i < NC; i++) m_off[i] = clampo(int'(poff[i*DW +: DW]), m_D);
      m_pend = 0;
      if (en) begin m_active = 1; m_drain = 0; m_pos = 0; end
    end else begin
      P = 2 * m_D;
      for (int i = 0; i < NC; i++) nenc[i] = (((m_pos - m_off[i] + P) % P) >= m_D);
      wrap = (m_pos == P - 1);
      stop = m_drain && !en && wrap;
      if (stop) nenc = '0;
      if (load) m_pend = 1;
      if (wrap) begin
        if (m_pend) begin
          m_D = fixd(m_sD);
          for (int i = 0; i < NC; i++) m_off[i] = clampo(m_soff[i], m_D);
        end
        m_pend = 0;
        m_pos = 0;
      end else begin
        m_pos++;
      end
      if (stop) m_active = 0;
      else m_drain = !en;
    end
    e_strb = nenc & ~e_enc;
    e_enc = nenc;
    if (e_strb[0]) e_cnt = (e_cnt + 1) % (1 << CW);
    e_run = m_active;
    e_div = m_D;
  endtask

  always begin
    @(posedge clk);
    model_step();
  end

  always begin
    @(negedge clk);
    if (cmp_on) begin
      chk("model_enc", enc, e_enc);
      chk("model_strobe", strb, e_strb);
      chk("model_count", cnt, e_cnt);
      chk("model_running", running, e_run);
      chk("model_div_active", div_act, e_div);
    end
  end

  // ---------------- directed scenarios ----------------
  task automatic adv();
    @(negedge clk);
    k++;
  endtask

  task automatic start(input logic [DW-1:0] d, input logic [NC*DW-1:0] off);
    @(negedge clk);
    rst = 1'b1; en = 1'b0; load = 1'b0; cdiv = d; poff = off;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    en = 1'b1;
    k = 0;
  endtask

  function automatic logic [NC-1:0] exp_phase(input int kk);
`ifdef ADC_ENC_PHASE_OFFSET_EN
    case (kk)
      6: return 4'b0001;
      8: return 4'b0010;
      10: return 4'b0100;
      13: return 4'b1000;
      default: return 4'b0000;
    endcase
`else
    return (kk == 6) ? 4'b1111 : 4'b0000;
`endif
  endfunction

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; cdiv = 16'd4; poff = '0;
    repeat (3) @(negedge clk);
    chk("reset_enc", enc, 0);
    chk("reset_strobe", strb, 0);
    chk("reset_count", cnt, 0);
    chk("reset_running", running, 0);
    chk("reset_div_active", div_act, 1);

    // basic divide D=4 and phase offsets {0,2,4,9}
    start(16'd4, {16'd9, 16'd4, 16'd2, 16'd0});
    for (int i = 0; i < 22; i++) begin
      adv();
      chk("basic_enc0", enc[0], (k >= 6) && (((k - 6) % 8) < 4));
      chk("basic_strobe0", strb[0], (k >= 6) && (((k - 6) % 8) == 0));
      if (k == 1) chk("start_running", running, 1);
      if (k == 6 || k == 8 || k == 10 || k == 13) chk("phase_strobes", strb, exp_phase(k));
    end
    chk("count_after_3_rises", cnt, 3);

    // reload at boundary, last load wins, load on wrap cycle
    start(16'd4, {16'd9, 16'd4, 16'd2, 16'd0});
    for (int i = 0; i < 52; i++) begin
      adv();
      if (k == 32) chk("reload_div_before", div_act, 4);
      if (k == 33) chk("reload_div_after", div_act, 2);
      if (k == 33) chk("reload_old_period_intact", enc[0], 1);
      if (k == 34) chk("reload_new_low", enc[0], 0);
      if (k == 36) chk("reload_first_rise", strb[0], 1);
      if (k == 38) chk("reload_fall", enc[0], 0);
      if (k == 40) chk("reload_period4", strb[0], 1);
      if (k == 44) chk("wrapload_div_before", div_act, 2);
      if (k == 45) chk("wrapload_div_after", div_act, 3);
      if (k == 49) chk("wrapload_rise", strb[0], 1);
      if (k == 51) chk("wrapload_high", enc[0], 1);
      if (k == 52) chk("wrapload_low", enc[0], 0);
      load = (k == 26) || (k == 28) || (k == 44);
      cdiv = (k == 26) ? 16'd5 : (k == 28) ? 16'd2 : (k == 44) ? 16'd3 : 16'd9;
    end
    load = 1'b0;

    // drain with restart, then a real stop
    start(16'd4, '0);
    for (int i = 0; i < 36; i++) begin
      adv();
      chk("stop_running", running, k <= 32);
      chk("stop_enc0", enc[0], (k <= 32) && (((k - 6) % 8) < 4) && (k >= 6));
      en = !((k == 11) || (k == 12) || (k >= 30));
    end

    // CLOCK_DIV=0 acts as 1; 4-bit count wraps
    start(16'd0, '0);
    for (int i = 0; i < 35; i++) begin
      adv();
      if (k <= 10) chk("div0_enc0", enc[0], (k >= 3) && ((k % 2) == 1));
      if (k == 1 || k == 20) chk("div0_div_active", div_act, 1);
      if (k == 31) chk("count_max", cnt, 15);
      if (k == 33) chk("count_wrap", cnt, 0);
      if (k == 35) chk("count_after_wrap", cnt, 1);
    end

    // reset mid-run discards a pending reload
    start(16'd4, '0);
    for (int i = 0; i < 20; i++) begin
      adv();
      if (k == 7) chk("midrun_enc_high", enc[0], 1);
      if (k == 8) begin
        chk("midrun_reset_enc", enc, 0);
        chk("midrun_reset_strobe", strb, 0);
        chk("midrun_reset_count", cnt, 0);
        chk("midrun_reset_running", running, 0);
        chk("midrun_reset_div", div_act, 1);
      end
      if (k == 14) chk("restart_rise", strb[0], 1);
      if (k == 14) chk("restart_count", cnt, 1);
      if (k == 17) chk("pending_discarded", div_act, 4);
      load = (k == 3);
      cdiv = (k == 3) ? 16'd2 : 16'd4;
      rst = (k == 7);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
